// File: rtl/baud_tick_gen.sv
// Programmable baud tick generator: divides clk_in into os_tick and every OVERSAMPLE-th into bit_tick.
// Optional fractional divisor when BAUD_FRAC_EN is defined (adds frac_value port and accumulator).
module baud_tick_gen #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 651,
  parameter int OVERSAMPLE  = 16
`ifdef BAUD_FRAC_EN
  ,
  parameter int FRAC_W      = 4
`endif
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          div_load,
  input  logic [DIV_W-1:0]              div_value,
  input  logic                          phase_clr,
`ifdef BAUD_FRAC_EN
  input  logic [FRAC_W-1:0]             frac_value,
`endif
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

  localparam int PH_W = $clog2(OVERSAMPLE);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] div_term;
  logic             wrap;
  logic             restart;

  // Divisors 0 and 1 would stall or tick continuously, so clamp to 2.
  always_comb begin
    div_eff = (div_reg < DIV_W'(2)) ? DIV_W'(2) : div_reg;
  end

  assign restart = div_load || phase_clr;
  assign wrap    = (div_cnt == div_term);

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   acc_sum;
  logic              stretch;

  assign acc_sum  = {1'b0, acc} + {1'b0, frac_value};
  // A carry out of the accumulator lengthens the following period by one cycle.
  assign div_term = div_eff - DIV_W'(1) + DIV_W'(stretch);

  always_ff @(posedge clk_in) begin
    if (!rst || restart) begin
      acc     <= '0;
      stretch <= 1'b0;
    end else if (en && wrap) begin
      acc     <= acc_sum[FRAC_W-1:0];
      stretch <= acc_sum[FRAC_W];
    end
  end
`else
  assign div_term = div_eff - DIV_W'(1);
`endif

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      div_reg  <= DIV_W'(DEFAULT_DIV);
      div_cnt  <= '0;
      os_phase <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else if (restart) begin
      if (div_load) begin
        div_reg <= div_value;
      end
      div_cnt  <= '0;
      os_phase <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else if (!en) begin
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      os_tick <= 1'b1;
      if (os_phase == PH_W'(OVERSAMPLE - 1)) begin
        os_phase <= '0;
        bit_tick <= 1'b1;
      end else begin
        os_phase <= os_phase + PH_W'(1);
        bit_tick <= 1'b0;
      end
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: a count-of-enabled-cycles model predicts every cycle's outputs.
module tb_baud_tick_gen;

  localparam int OS  = 16;
  localparam int DEF = 651;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        en;
  logic        div_load;
  logic [15:0] div_value;
  logic        phase_clr;
  logic        os_tick;
  logic        bit_tick;
  logic [3:0]  os_phase;

  always #5 clk_in = ~clk_in;

  baud_tick_gen dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .div_load  (div_load),
    .div_value (div_value),
    .phase_clr (phase_clr),
`ifdef BAUD_FRAC_EN
    .frac_value(4'd0),
`endif
    .os_tick   (os_tick),
    .bit_tick  (bit_tick),
    .os_phase  (os_phase)
  );

  typedef struct packed {
    logic       os;
    logic       bt;
    logic [3:0] ph;
  } exp_t;

  exp_t q[$];
  int vectors     = 0;
  int miscompares = 0;

  // Model state: divisor and number of enabled cycles since the last clear.
  int m_div = DEF;
  int m_n   = 0;

  task automatic step(input logic r, input logic e, input logic dl, input int dv, input logic pc);
    exp_t x;
    int   deff;
    rst       = r;
    en        = e;
    div_load  = dl;
    div_value = 16'(dv);
    phase_clr = pc;
    if (!r) begin
      m_div = DEF;
      m_n   = 0;
    end else if (dl) begin
      m_div = dv;
      m_n   = 0;
    end else if (pc) begin
      m_n = 0;
    end else if (e) begin
      m_n++;
    end
    deff = (m_div < 2) ? 2 : m_div;
    x.os = r && !dl && !pc && e && (m_n % deff == 0);
    x.bt = x.os && (m_n % (deff * OS) == 0);
    x.ph = 4'((m_n / deff) % OS);
    q.push_back(x);
    @(posedge clk_in);
    #1;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b1, 1'b0, 0, 1'b0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk_in);
      if (q.size() > 0) begin
        x = q.pop_front();
        vectors++;
        if ({os_tick, bit_tick, os_phase} !== x) begin
          miscompares++;
          $display("FAIL tick_check t=%0t got os=%b bt=%b ph=%0d want os=%b bt=%b ph=%0d",
                   $time, os_tick, bit_tick, os_phase, x.os, x.bt, x.ph);
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0);

    // divisor 4: ticks every 4 cycles, bit tick at 64
    step(1'b1, 1'b1, 1'b1, 4, 1'b0);
    run(70);

    // clamped divisors
    step(1'b1, 1'b1, 1'b1, 0, 1'b0);
    run(10);
    step(1'b1, 1'b1, 1'b1, 1, 1'b0);
    run(10);

    // enable gap mid-period
    step(1'b1, 1'b1, 1'b1, 10, 1'b0);
    run(5);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    run(20);

    // phase_clr at div_cnt=6, os_phase=9; then load+clear together
    step(1'b1, 1'b1, 1'b1, 8, 1'b0);
    run(8 * 9 + 6);
    step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    run(20);
    step(1'b1, 1'b1, 1'b1, 5, 1'b1);
    run(30);

    // reset mid-period at os_phase=15, then long run at the default divisor
    step(1'b1, 1'b1, 1'b1, 4, 1'b0);
    run(4 * 15 + 3);
    step(1'b0, 1'b1, 1'b1, 9, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 1'b0);
    run(16 * DEF + 10);

    // randomized traffic with small divisors
    step(1'b1, 1'b1, 1'b1, 3, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 99) == 0,
           int'($urandom_range(0, 12)),
           $urandom_range(0, 99) == 0);
    end

    guard = 0;
    while (q.size() > 0 && guard < 5) begin
      @(negedge clk_in);
      #1;
      guard++;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
